// File: rtl/ram_pipelined_if.sv
// ---------------------------------------------------------------------------
// ram_pipelined_if
//   Request/response bundle between a memory client (master) and the
//   pipelined RAM (slave).
//
//   req         request valid, qualified by ready
//   we          1 = write, 0 = read
//   byte_en     write byte lanes, bit i covers write_data[8i+7:8i]
//   address     word address
//   write_data  write data
//   ready       request accepted on this cycle when req && ready
//   read_valid  one-cycle strobe per accepted read
//   read_data   read data, zero whenever read_valid is low
//   init_start  one-cycle pulse that starts the clear sequence
//   init_busy   high while the clear sequence runs
// ---------------------------------------------------------------------------
interface ram_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    ready;
    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    init_start;
    logic                    init_busy;

    modport master (
        output req, we, byte_en, address, write_data, init_start,
        input  ready, read_valid, read_data, init_busy
    );

    modport slave (
        input  req, we, byte_en, address, write_data, init_start,
        output ready, read_valid, read_data, init_busy
    );
endinterface

// File: rtl/ram_pipelined.sv
// ---------------------------------------------------------------------------
// ram_pipelined
//   Single-port synchronous RAM with byte-enable writes, a read pipeline of
//   READ_LATENCY cycles with a valid strobe, a req/ready handshake and a
//   hardware clear sequencer that writes INIT_VALUE to every word.
//   Memory contents are not affected by reset.
//
//   clk_i    clock, all state changes on the rising edge
//   rst_n_i  asynchronous active-low reset (control state only)
//   bus      ram_pipelined_if.slave request/response bundle
// ---------------------------------------------------------------------------
module ram_pipelined #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    ram_pipelined_if.slave bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("ram_pipelined: READ_LATENCY must be in 1..4");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("ram_pipelined: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    logic                  in_init;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_lanes;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;

    // InitStart blocks acceptance in the same cycle so no request can slip
    // in on the edge that enters the clear sequence.
    assign in_init   = (state_q == ST_INIT);
    assign bus.ready = (state_q == ST_IDLE) && !bus.init_start;
    assign accept    = bus.req && bus.ready;
    assign wr_accept = accept && bus.we;
    assign rd_accept = accept && !bus.we;

    // One shared write port: the clear sequencer owns it while in INIT,
    // since no requests are accepted then.
    assign wr_en   = wr_accept || in_init;
    assign wr_addr = in_init ? init_cnt_q : bus.address;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_data[8*gi +: 8] = in_init ? INIT_VALUE[8*gi +: 8]
                                                : bus.write_data[8*gi +: 8];
            assign wr_lanes[gi]       = in_init | bus.byte_en[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.init_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                // All-ones counter is the last address, DEPTH-1.
                if (&init_cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            vld_q[0]   <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Memory array and read data pipeline carry no reset so the array maps
    // onto block RAM; stale pipeline data is hidden by the output gating.
    // Read is read-before-write, but reads and writes never share an edge.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_lanes[i]) begin
                mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_accept) begin
            dat_q[0] <= mem_q[bus.address];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign bus.read_valid = vld_q[READ_LATENCY-1];
    assign bus.read_data  = vld_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1]
                                                  : '0;
    assign bus.init_busy  = in_init;
endmodule

// File: tb/tb_ram_pipelined.sv
// ---------------------------------------------------------------------------
// tb_ram_pipelined
//   Bench for ram_pipelined (DATA_WIDTH 32, ADDR_WIDTH 4, READ_LATENCY 3,
//   INIT_VALUE 0x5A5A5A5A). A word-array model with a queue of due read
//   responses predicts every cycle's ready/init_busy/read outputs.
// ---------------------------------------------------------------------------
module tb_ram_pipelined;
    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          LAT   = 3;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INITV = 32'h5A5A5A5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    ram_pipelined #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(LAT),
        .INIT_VALUE  (INITV)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus_if)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
        bit          has_exp;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];
    rd_t         rq[$];
    int          init_rem = 0;
    int          init_ptr = 0;
    vec_t        vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit req, input bit we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] wd, input bit init);
        bus_if.req        = req;
        bus_if.we         = we;
        bus_if.byte_en    = be;
        bus_if.address    = addr;
        bus_if.write_data = wd;
        bus_if.init_start = init;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // One clock: check outputs mid-cycle, then advance the model over the edge.
    task automatic cycle(input bit has_exp = 1'b0, input logic [31:0] exp = 32'h0);
        bit  exp_ready;
        rd_t e;
        @(negedge clk);
        exp_ready = (init_rem == 0) && !bus_if.init_start;
        chk("ready", {31'b0, bus_if.ready}, {31'b0, exp_ready});
        chk("init_busy", {31'b0, bus_if.init_busy}, {31'b0, init_rem != 0});
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            chk("rd_valid", {31'b0, bus_if.read_valid}, 32'h1);
            if (e.known)   chk("rd_data", bus_if.read_data, e.data);
            if (e.has_exp) chk("rd_vector", bus_if.read_data, e.exp);
            $display("txn cycle %0d read response data=%h", cyc, bus_if.read_data);
        end else begin
            chk("rd_valid_idle", {31'b0, bus_if.read_valid}, 32'h0);
            chk("rd_data_idle", bus_if.read_data, 32'h0);
        end
        @(posedge clk);
        cyc++;
        if (bus_if.req && exp_ready) begin
            if (bus_if.we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_if.byte_en[i])
                        model_mem[bus_if.address][8*i +: 8] = bus_if.write_data[8*i +: 8];
                end
                if (bus_if.byte_en == 4'hF) model_known[bus_if.address] = 1'b1;
                $display("txn cycle %0d write addr=%0d be=%h data=%h", cyc,
                         bus_if.address, bus_if.byte_en, bus_if.write_data);
            end else begin
                e.due     = cyc + LAT - 1;
                e.data    = model_mem[bus_if.address];
                e.known   = model_known[bus_if.address];
                e.has_exp = has_exp;
                e.exp     = exp;
                rq.push_back(e);
                $display("txn cycle %0d read accept addr=%0d", cyc, bus_if.address);
            end
        end
        if (init_rem > 0) begin
            model_mem[init_ptr]   = INITV;
            model_known[init_ptr] = 1'b1;
            init_ptr++;
            init_rem--;
        end else if (bus_if.init_start) begin
            init_rem = DEPTH;
            init_ptr = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, bus_if.ready}, 32'h1);
        chk("rst_valid", {31'b0, bus_if.read_valid}, 32'h0);
        chk("rst_data", bus_if.read_data, 32'h0);
        chk("rst_busy", {31'b0, bus_if.init_busy}, 32'h0);
        rq.delete();
        init_rem = 0;
        init_ptr = 0;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rst_n = 1'b1;
        $display("txn cycle %0d reset", cyc);
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 1) cycle();
    endtask

    task automatic wait_init_done(input string name);
        int busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus_if.init_busy && k > 0) break;
            if (bus_if.init_busy) busy_cnt++;
            // Requests offered during the clear must be refused.
            drive(1'b1, k[0], 4'hF, k[3:0], 32'h0BAD0000 | k, k == 5);
            cycle();
        end
        idle();
        chk(name, busy_cnt, DEPTH);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
        vt[0]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 32'h0};
        vt[1]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 32'h0};
        vt[2]  = '{1'b0, 4'h0, 4'd5,  32'h0,        32'hAA22CC44};
        vt[3]  = '{1'b1, 4'hF, 4'd9,  32'hDEADBEEF, 32'h0};
        vt[4]  = '{1'b0, 4'h0, 4'd9,  32'h0,        32'hDEADBEEF};
        vt[5]  = '{1'b1, 4'hF, 4'd1,  32'h01010101, 32'h0};
        vt[6]  = '{1'b1, 4'hF, 4'd2,  32'h02020202, 32'h0};
        vt[7]  = '{1'b1, 4'hF, 4'd3,  32'h03030303, 32'h0};
        vt[8]  = '{1'b0, 4'h0, 4'd1,  32'h0,        32'h01010101};
        vt[9]  = '{1'b0, 4'h0, 4'd2,  32'h0,        32'h02020202};
        vt[10] = '{1'b0, 4'h0, 4'd3,  32'h0,        32'h03030303};
        vt[11] = '{1'b1, 4'h0, 4'd5,  32'hFFFFFFFF, 32'h0};
        vt[12] = '{1'b0, 4'h0, 4'd5,  32'h0,        32'hAA22CC44};
        vt[13] = '{1'b1, 4'h8, 4'd9,  32'h77000000, 32'h0};
        vt[14] = '{1'b0, 4'h0, 4'd9,  32'h0,        32'h77ADBEEF};
        vt[15] = '{1'b1, 4'h2, 4'd12, 32'h00000000, 32'h0};
        vt[16] = '{1'b0, 4'h0, 4'd12, 32'h0,        32'h5A5A005A};

        idle();
        #2;
        do_reset();

        // Full clear with refused requests and an ignored second InitStart.
        drive(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1);
        cycle();
        wait_init_done("init_busy_cycles");
        drive(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        cycle(1'b1, INITV);
        drive(1'b1, 1'b0, 4'h0, 4'd15, 32'h0, 1'b0);
        cycle(1'b1, INITV);
        drain();

        // Reset while responses are in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b0);
            cycle();
        end
        do_reset();

        // Directed vector table, back to back.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vt[i].we, vt[i].be, vt[i].addr, vt[i].wd, 1'b0);
            cycle(!vt[i].we, vt[i].exp);
        end
        drain();

        // Read accepted just before the clear returns pre-clear data.
        drive(1'b1, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0);
        cycle(1'b1, 32'h12345678);
        drive(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1);
        cycle();
        wait_init_done("init2_busy_cycles");
        drive(1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b0);
        cycle(1'b1, INITV);
        drain();

        // Clear aborted by reset after four words.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 4'hF, 4'(i), 32'hC0DE0000 | i, 1'b0);
            cycle();
        end
        drive(1'b1, 1'b1, 4'hF, 4'd10, 32'hCAFEF00D, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
        cycle();
        idle();
        repeat (4) cycle();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b0);
            cycle(1'b1, INITV);
        end
        drive(1'b1, 1'b0, 4'h0, 4'd4, 32'h0, 1'b0);
        cycle(1'b1, 32'hC0DE0004);
        drive(1'b1, 1'b0, 4'h0, 4'd10, 32'h0, 1'b0);
        cycle(1'b1, 32'hCAFEF00D);
        drain();

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                  4'($urandom), $urandom, $urandom_range(0, 99) == 0);
            cycle();
        end
        idle();
        repeat (DEPTH + LAT + 2) cycle();
        chk("queue_empty", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
